// File: rtl/sbqm_teller_dispatcher.sv
// Teller-side dispatcher: counts waiting customers, arbitrates free tellers, calls tickets.
// Define SBQM_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed lowest-index priority.
module sbqm_teller_dispatcher #(
  parameter int HOLD_CYCLES = 4,
  parameter int QMAX        = 7
) (
  input  logic       clk1,
  input  logic       rst1,
  input  logic       in1,
  input  logic [1:0] Tcount,
  input  logic [2:0] tfree,
  output logic       out1,
  output logic [2:0] tack,
  output logic       call_valid,
  output logic [1:0] call_teller,
  output logic [4:0] call_ticket,
  output logic [4:0] next_ticket,
  output logic [2:0] qcount,
  output logic       empty,
  output logic       full
);

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t     state;
  logic [4:0] serve_ptr;
  logic [3:0] hold_cnt;
  logic [1:0] n_en;
  logic [2:0] enable_mask;
  logic [2:0] eligible;
  logic [1:0] winner;
  logic       has_winner;
  logic       accept;
  logic       dispatch;

  // A Tcount of zero still leaves teller 0 in service.
  assign n_en     = (Tcount == 2'd0) ? 2'd1 : Tcount;
  assign eligible = tfree & enable_mask;
  assign accept   = in1 && !full;
  assign dispatch = (state == GRANT);
  assign empty    = (qcount == 3'd0);
  assign full     = (qcount == 3'(QMAX));

  always_comb begin
    case (n_en)
      2'd1:    enable_mask = 3'b001;
      2'd2:    enable_mask = 3'b011;
      default: enable_mask = 3'b111;
    endcase
  end

`ifdef SBQM_ROUND_ROBIN_EN
  logic [1:0] rr_ptr;
  logic [2:0] start;
  logic [2:0] cand;

  // Search begins one past the last grant, wrapping within the enabled tellers.
  always_comb begin
    winner     = 2'd0;
    has_winner = 1'b0;
    cand       = 3'd0;
    start      = {1'b0, rr_ptr} + 3'd1;
    if (start >= {1'b0, n_en}) start = 3'd0;
    for (int k = 0; k < 3; k++) begin
      if (!has_winner && (3'(k) < {1'b0, n_en})) begin
        cand = start + 3'(k);
        if (cand >= {1'b0, n_en}) cand = cand - {1'b0, n_en};
        if (eligible[cand[1:0]]) begin
          winner     = cand[1:0];
          has_winner = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    winner     = 2'd0;
    has_winner = |eligible;
    if (eligible[0])      winner = 2'd0;
    else if (eligible[1]) winner = 2'd1;
    else if (eligible[2]) winner = 2'd2;
  end
`endif

  always_ff @(posedge clk1) begin
    if (rst1) begin
      state       <= IDLE;
      out1        <= 1'b0;
      tack        <= 3'b000;
      call_valid  <= 1'b0;
      call_teller <= 2'd0;
      call_ticket <= 5'd0;
      next_ticket <= 5'd0;
      serve_ptr   <= 5'd0;
      qcount      <= 3'd0;
      hold_cnt    <= 4'd0;
`ifdef SBQM_ROUND_ROBIN_EN
      rr_ptr      <= 2'd2;
`endif
    end else begin
      if (accept) next_ticket <= next_ticket + 5'd1;
      if (accept && !dispatch)      qcount <= qcount + 3'd1;
      else if (!accept && dispatch) qcount <= qcount - 3'd1;

      case (state)
        IDLE: begin
          if (qcount != 3'd0 && has_winner) begin
            state       <= GRANT;
            out1        <= 1'b1;
            tack        <= 3'b001 << winner;
            call_teller <= winner;
            call_ticket <= serve_ptr;
            call_valid  <= 1'b1;
          end
        end
        GRANT: begin
          out1      <= 1'b0;
          tack      <= 3'b000;
          serve_ptr <= serve_ptr + 5'd1;
          hold_cnt  <= 4'(HOLD_CYCLES - 1);
          state     <= HOLD;
`ifdef SBQM_ROUND_ROBIN_EN
          rr_ptr    <= call_teller;
`endif
        end
        HOLD: begin
          if (hold_cnt == 4'd0) begin
            state      <= IDLE;
            call_valid <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sbqm_teller_dispatcher.md
# sbqm_teller_dispatcher

Teller-side dispatcher for the bank queue manager. It tracks the customers waiting in the queue from entry pulses on `in1`, and arbitrates among free tellers. It calls the next ticket to a selected teller and generates the one-cycle customer-leaves pulse `out1` that feeds the people counter and waiting-time lookup. It is the consumer end of the `in1`/`out1` queue protocol, where the lookup path is the producer end.

## Interface
Parameters:
- `HOLD_CYCLES`, default 4: cycles a call stays displayed after dispatch. Legal range is 1..15.
- `QMAX`, default 7: maximum queue occupancy. It matches the 3-bit people count.

Ports:
- `clk1`, in, 1: single clock. All logic is on the rising edge.
- `rst1`, in, 1: reset, synchronous and active-high.
- `in1`, in, 1: customer-entered pulse. One cycle per customer.
- `Tcount`, in, 2: number of active tellers, 1..3. A value of 0 is treated as 1. Teller i is enabled iff i < Tcount.
- `tfree`, in, 3: level requests. Bit i is high while teller i is free to serve.
- `out1`, out, 1: one-cycle pulse, one customer dispatched.
- `tack`, out, 3: one-hot grant to the served teller. It is coincident with `out1`.
- `call_valid`, out, 1: a call is being displayed.
- `call_teller`, out, 2: index of the called teller.
- `call_ticket`, out, 5: ticket number being called.
- `next_ticket`, out, 5: ticket number the next entering customer receives.
- `qcount`, out, 3: customers waiting.
- `empty`, out, 1: high when `qcount` is 0.
- `full`, out, 1: high when `qcount` equals `QMAX`.

## Operation
- Ticket pointers:
  - `next_ticket` increments on an accepted `in1`.
  - The internal `serve_ptr` increments on dispatch.
  - Both are 5-bit and wrap from 31 to 0.
- Queue count:
  - An accepted `in1` adds 1 to `qcount`. `in1` is accepted only when not full; when `full`, `in1` is ignored and no ticket is issued.
  - A dispatch subtracts 1.
  - A simultaneous accepted `in1` and dispatch leaves `qcount` unchanged while both pointers advance.
- The eligible mask is `tfree & enable(Tcount)`, sampled only in IDLE.
- State machine states: IDLE, GRANT, HOLD.
  - IDLE goes to GRANT when `qcount` > 0 and the eligible mask is non-zero. The winner is latched into `call_teller`.
  - GRANT lasts exactly 1 cycle. In it:
    - `out1` = 1 and `tack[call_teller]` = 1.
    - `call_ticket` takes `serve_ptr`.
    - `serve_ptr` increments and `qcount` decrements.
    - GRANT then goes to HOLD.
  - HOLD: `call_valid` = 1 for `HOLD_CYCLES` cycles, then IDLE. `call_teller` and `call_ticket` hold their values until the next GRANT.
- `call_valid` is also high during GRANT.
- Changes to `Tcount` or `tfree` during GRANT or HOLD do not affect the call in progress.
- Tellers must drop `tfree` on `tack`. A teller that keeps `tfree` high becomes eligible again in the next IDLE.

## Timing
- Reset values:
  - `out1`, `tack`, `call_valid`, `call_teller`, `call_ticket`, `next_ticket`, `qcount`, `full`: 0.
  - `empty`: 1.
  - State: IDLE.
  - Round-robin pointer: teller 2, so teller 0 wins first.
- `rst1` takes priority over everything. If asserted in any state, all outputs take their reset values at the next edge. `in1` in the reset cycle is lost.
- Dispatch latency:
  - The condition is true in IDLE at edge N, so GRANT, `out1`, and `tack` are visible in cycle N+1.
  - HOLD occupies cycles N+2 .. N+1+`HOLD_CYCLES`.
  - IDLE resumes after that.
- Minimum spacing between `out1` pulses is `HOLD_CYCLES` + 2 cycles.
- `qcount`, `empty`, `full` and `next_ticket` are registered. They update one edge after the causing event.
- `in1` is accepted in every state, including GRANT and HOLD.

## Configuration
- `SBQM_ROUND_ROBIN_EN` defined: round-robin arbitration.
  - The search starts at last granted + 1, modulo the enabled teller count, and skips disabled tellers.
  - The pointer updates only in GRANT.
- Not defined: fixed priority. The lowest eligible index wins, and there is no pointer register.

## Test plan
- Reset, then `in1` for 3 cycles with `tfree` = 0: `qcount` = 3, `next_ticket` = 3, `empty` = 0, no `out1`.
- `qcount` = 2, `Tcount` = 2, `tfree` = 011 held. With `SBQM_ROUND_ROBIN_EN`: first grant to teller 0 with ticket 0, second to teller 1 with ticket 1, `out1` spacing 6 cycles (`HOLD_CYCLES` = 4). Without the macro, both grants go to teller 0.
- 8 `in1` pulses with no tellers free: `qcount` saturates at 7 and `full` = 1. The 8th pulse leaves `next_ticket` at 7.
- `in1` in the GRANT cycle at `qcount` = 1: `qcount` stays 1, `next_ticket` and `serve_ptr` both advance.
- `tfree` = 100 with `Tcount` = 2: no grant. Changing `Tcount` to 3 gives a grant to teller 2 one cycle later.
- `rst1` asserted during HOLD with `qcount` = 4: the next cycle shows `call_valid` = 0, `qcount` = 0, `empty` = 1, state IDLE.
